// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master behind a one-beat command/response port,
// with a hung-bus timeout that abandons a stalled transaction and reports SLVERR.
module axil_cmd_master #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WRITE,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [31:0]   CMD_WDATA,
    output logic          RSP_VALID,
    output logic [31:0]   RSP_RDATA,
    output logic [1:0]    RSP_RESP,
    output logic          RSP_TIMEOUT,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [2:0]    M_AXI_AWPROT,
    output logic [31:0]   M_AXI_WDATA,
    output logic          M_AXI_WVALID,
    output logic [3:0]    M_AXI_WSTRB,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic          M_AXI_RVALID,
    input  logic [1:0]    M_AXI_RRESP,
    output logic          M_AXI_RREADY
);

    // Counter only needs to reach TIMEOUT-1; the abort fires on the cycle it sits there.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t state, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (state != IDLE) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state         <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = (state == IDLE) ? '0 : cnt_q + CW'(1);
        done          = 1'b0;

        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    if (CMD_WRITE) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W channels retire independently, in either order.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    done          = 1'b1;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    done          = 1'b1;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion landing on the final count wins over the abort.
        if (timeout_hit && !done) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'd2;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
        end
    end

    assign CMD_READY     = (state == IDLE);
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign RSP_TIMEOUT   = rsp_timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: drives commands against an adder-style
// AXI4-Lite slave model with tunable ready/response delays and an AR stall control.
module tb_axil_cmd_master;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, s_rdata;
    logic [3:0]  wstrb;
    logic [1:0]  s_bresp, s_rresp;

    axil_cmd_master #(.AW(8), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
        .RSP_TIMEOUT(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_AWPROT(awprot), .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid),
        .M_AXI_WSTRB(wstrb), .M_AXI_WREADY(wready), .M_AXI_BRESP(s_bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARPROT(arprot),
        .M_AXI_RDATA(s_rdata), .M_AXI_RVALID(rvalid), .M_AXI_RRESP(s_rresp),
        .M_AXI_RREADY(rready)
    );

    // Adder slave model: 0x0 = a, 0x4 = b, 0x8 = a+b (read), anything else DECERR.
    logic [31:0] reg_a, reg_b, s_wdata, wr_d;
    logic [7:0]  s_awaddr, wr_a;
    logic        got_aw, got_w, b_pend, r_pend, ar_block;
    int          aw_cnt, w_cnt, b_cnt, n_wr, n_rd;
    int          aw_delay, w_delay, b_delay;

    assign awready = awvalid && !got_aw && !b_pend && (aw_cnt >= aw_delay);
    assign wready  = wvalid && !got_w && !b_pend && (w_cnt >= w_delay);
    assign bvalid  = b_pend && (b_cnt >= b_delay);
    assign arready = arvalid && !r_pend && !ar_block;
    assign rvalid  = r_pend;
    assign wr_a    = got_aw ? s_awaddr : awaddr;
    assign wr_d    = got_w ? s_wdata : wdata;

    always @(posedge clk) begin
        if (!resetn) begin
            reg_a <= 0; reg_b <= 0; s_wdata <= 0; s_awaddr <= 0;
            got_aw <= 0; got_w <= 0; b_pend <= 0; r_pend <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; n_wr <= 0; n_rd <= 0;
            s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awready) begin got_aw <= 1; s_awaddr <= awaddr; end
            if (wready)  begin got_w <= 1; s_wdata <= wdata; end
            if ((got_aw || awready) && (got_w || wready)) begin
                got_aw <= 0; got_w <= 0; b_pend <= 1; b_cnt <= 0; n_wr <= n_wr + 1;
                case (wr_a)
                    8'h0:    begin reg_a <= wr_d; s_bresp <= 2'd0; end
                    8'h4:    begin reg_b <= wr_d; s_bresp <= 2'd0; end
                    8'h8:    s_bresp <= 2'd0;
                    default: s_bresp <= 2'd3;
                endcase
            end else if (b_pend && !bvalid) begin
                b_cnt <= b_cnt + 1;
            end
            if (bvalid && bready) b_pend <= 0;
            if (arready) begin
                r_pend <= 1; n_rd <= n_rd + 1;
                case (araddr)
                    8'h0:    begin s_rdata <= reg_a; s_rresp <= 2'd0; end
                    8'h4:    begin s_rdata <= reg_b; s_rresp <= 2'd0; end
                    8'h8:    begin s_rdata <= reg_a + reg_b; s_rresp <= 2'd0; end
                    default: begin s_rdata <= 0; s_rresp <= 2'd3; end
                endcase
            end
            if (rvalid && rready) r_pend <= 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the response pulse (lat = -1 if none).
    task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [1:0] rs,
                          output logic to, output int lat);
        int t0, n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        lat = rsp_valid ? cyc - t0 : -1;
    endtask

    localparam logic        B2B_WR   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0]  B2B_ADDR [6] = '{8'h0, 8'h0, 8'h4, 8'h8, 8'h0, 8'h8};
    localparam logic [31:0] B2B_WD   [6] = '{32'd3, 32'd0, 32'd9, 32'd0, 32'd1, 32'd0};
    localparam logic [31:0] B2B_RD   [6] = '{32'd0, 32'd3, 32'd0, 32'd12, 32'd0, 32'd10};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int          lat, n, t0, w_drop, aw_drop, rsp_at, pulses, ar_hi;

        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_block = 0;
        resetn = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("const_wstrb_prot", {wstrb, awprot, arprot}, 32'h3C0);
        resetn = 1;
        @(negedge clk);

        // Adder: 5 + 7 = 12, each response three cycles after accept.
        do_cmd(1'b1, 8'h0, 32'd5, rd, rs, to, lat);
        chk("wr0_lat", lat, 3); chk("wr0_resp", 32'(rs), 0); chk("wr0_to", 32'(to), 0);
        chk("wr0_cmd_ready", 32'(cmd_ready), 1);
        do_cmd(1'b1, 8'h4, 32'd7, rd, rs, to, lat);
        chk("wr4_lat", lat, 3); chk("wr4_resp", 32'(rs), 0);
        do_cmd(1'b0, 8'h8, 32'd0, rd, rs, to, lat);
        chk("rd8_lat", lat, 3); chk("rd8_data", rd, 12); chk("rd8_resp", 32'(rs), 0);
        chk("rd8_to", 32'(to), 0);

        // Unmapped address returns DECERR on both paths.
        do_cmd(1'b1, 8'hC, 32'd1, rd, rs, to, lat);
        chk("wrC_resp", 32'(rs), 3); chk("wrC_to", 32'(to), 0);
        do_cmd(1'b0, 8'hC, 32'd0, rd, rs, to, lat);
        chk("rdC_resp", 32'(rs), 3);

        // W accepted 4 cycles before AW, B two cycles after AW.
        aw_delay = 4; b_delay = 2;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h0; cmd_wdata = 32'd20;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        w_drop = -1; aw_drop = -1; rsp_at = -1; pulses = 0;
        @(negedge clk);
        cmd_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!wvalid && w_drop < 0) w_drop = k;
            if (!awvalid && aw_drop < 0) aw_drop = k;
            if (rsp_valid) begin pulses++; if (rsp_at < 0) rsp_at = k; end
            if (k == 4) chk("ord_aw_held_w_low", {awvalid, wvalid}, 2'b10);
            if (k == 6) chk("ord_bready", 32'(bready), 1);
            @(negedge clk);
        end
        chk("ord_w_drop", w_drop, 2); chk("ord_aw_drop", aw_drop, 6);
        chk("ord_rsp_at", rsp_at, 9); chk("ord_pulses", pulses, 1);
        aw_delay = 0; b_delay = 0;
        do_cmd(1'b0, 8'h8, 32'd0, rd, rs, to, lat);
        chk("rd8b_data", rd, 27); chk("rd8b_lat", lat, 3);

        // Slave never takes AR: abandon after 16 cycles of ARVALID.
        ar_block = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h8;
        @(negedge clk);
        cmd_valid = 0;
        chk("to_araddr", 32'(araddr), 8);
        ar_hi = 0; n = 0;
        while (arvalid && n < 100) begin ar_hi++; @(negedge clk); n++; end
        chk("to_ar_cycles", ar_hi, 16);
        chk("to_rsp_valid", 32'(rsp_valid), 1);
        chk("to_flag", 32'(rsp_timeout), 1);
        chk("to_resp", 32'(rsp_resp), 2);
        chk("to_rdata_kept", rsp_rdata, 27);
        chk("to_cmd_ready", 32'(cmd_ready), 1);
        ar_block = 0;
        do_cmd(1'b0, 8'h8, 32'd0, rd, rs, to, lat);
        chk("after_to_data", rd, 27); chk("after_to_flag", 32'(to), 0);
        chk("after_to_resp", 32'(rs), 0); chk("after_to_lat", lat, 3);

        // Reset pulse while waiting for B.
        b_delay = 10;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h4; cmd_wdata = 32'd9;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        chk("mid_in_wr_resp", 32'(bready), 1);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        chk("mid_bready", 32'(bready), 0);
        chk("mid_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk("mid_rdata", rsp_rdata, 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("mid_no_rsp", pulses, 0);
        b_delay = 0;

        // CMD_VALID held high; each new command presented on the response cycle.
        cmd_valid = 1; cmd_write = B2B_WR[0]; cmd_addr = B2B_ADDR[0]; cmd_wdata = B2B_WD[0];
        chk("b2b_ready0", 32'(cmd_ready), 1);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
            chk($sformatf("b2b%0d_lat", i), rsp_valid ? cyc - t0 : -1, 3);
            chk($sformatf("b2b%0d_resp", i), 32'(rsp_resp), 0);
            if (!B2B_WR[i]) chk($sformatf("b2b%0d_rdata", i), rsp_rdata, B2B_RD[i]);
            chk($sformatf("b2b%0d_ready", i), 32'(cmd_ready), 1);
            t0 = cyc;
            if (i < 5) begin
                cmd_write = B2B_WR[i+1]; cmd_addr = B2B_ADDR[i+1]; cmd_wdata = B2B_WD[i+1];
            end else begin
                cmd_valid = 0;
            end
        end
        repeat (5) @(negedge clk);
        chk("b2b_n_wr", n_wr, 3);
        chk("b2b_n_rd", n_rd, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Upstream AXI4-Lite master that feeds our AXI4-Lite register slaves (e.g. the adder example block).
- Converts a simple single-beat command/response interface into AXI4-Lite write or read transactions.
- Supports one outstanding transaction.
- Includes a hung-bus timeout so firmware-style sequencers and test logic never lock up.

Parameters:
AW, 8, AXI address width in bits
TIMEOUT, 1024, cycles from command accept to abandon; 0 disables the timeout

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  command accepted when VALID&READY
CMD_WRITE  in  1  1=write, 0=read
CMD_ADDR  in  AW  byte address
CMD_WDATA  in  32  write data
RSP_VALID  out  1  one-cycle pulse, response available
RSP_RDATA  out  32  read data (held until next RSP_VALID)
RSP_RESP  out  2  BRESP/RRESP, or SLVERR(2) on timeout
RSP_TIMEOUT  out  1  1 = transaction abandoned (valid with RSP_VALID)
M_AXI_AWADDR  out  AW
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_AWPROT  out  3  constant 0
M_AXI_WDATA  out  32
M_AXI_WVALID  out  1
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  AW
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_ARPROT  out  3  constant 0
M_AXI_RDATA  in  32
M_AXI_RVALID  in  1
M_AXI_RRESP  in  2
M_AXI_RREADY  out  1

Behaviour:
- Reset: state=IDLE. All AXI VALID/READY outputs 0. RSP_VALID=0, RSP_TIMEOUT=0, RSP_RESP=0, RSP_RDATA=0. Timeout counter=0.
- CMD_READY = (state==IDLE); combinational from the state register.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: on CMD_VALID&CMD_READY at cycle N:
  - Register addr/data; CMD_ADDR passes through unaltered.
  - Write: AWVALID and WVALID both 1 at N+1; go to WR_ADDR_DATA.
  - Read: ARVALID=1 at N+1; go to RD_ADDR.
  - Counter cleared.
- WR_ADDR_DATA:
  - AWVALID drops the cycle after its AWREADY handshake; WVALID drops the cycle after its WREADY handshake. The two are independent.
  - Either order is allowed, including the same cycle.
  - Once both are done: BREADY=1, go to WR_RESP.
  - AWADDR/WDATA stay stable while the corresponding VALID is high.
- WR_RESP: on BVALID&BREADY:
  - BREADY=0 next cycle.
  - RSP_RESP<=BRESP, RSP_VALID pulses next cycle.
  - Go to IDLE.
- RD_ADDR: on ARREADY, ARVALID drops next cycle; RREADY=1; go to RD_DATA.
- RD_DATA: on RVALID&RREADY:
  - RSP_RDATA<=RDATA, RSP_RESP<=RRESP, RSP_VALID pulse.
  - RREADY=0; go to IDLE.
- Best-case latency, 0-wait slave:
  - Write: accept N, AW/W handshake N+1, BREADY N+2, BVALID N+2, RSP_VALID N+3.
  - Read: same shape, RSP_VALID N+3.
- RSP_VALID is not backpressured. The consumer must sample it on the pulse cycle.
- CMD_READY returns high in the same cycle RSP_VALID pulses.
- Timeout (TIMEOUT>0):
  - Counter increments every cycle outside IDLE.
  - On reaching TIMEOUT without completion: all AXI VALID/READY go 0 next cycle, RSP_VALID=1, RSP_TIMEOUT=1, RSP_RESP=2, go to IDLE. RSP_RDATA is unchanged.
  - This deliberately violates AXI and is for hung-bus recovery only.
  - A completion handshake in the same cycle the count is reached wins: normal response, RSP_TIMEOUT=0.
- RSP_TIMEOUT is 0 on every normal response.
- Reset mid-transaction: all outputs return to reset values next clock. No response is issued.
- CMD_VALID high outside IDLE is ignored; the command is not accepted.
- Back-to-back commands: a second command held on CMD_VALID is accepted on the RSP_VALID cycle.

Test Plan:
- Against the adder slave: write 5 to addr 0x0, write 7 to addr 0x4, read 0x8 -> RSP_RDATA=12, RSP_RESP=0, each RSP_VALID 3 cycles after accept.
- Write to 0xC on the adder slave -> RSP_RESP=3 (DECERR), RSP_TIMEOUT=0. Read 0xC -> RSP_RESP=3.
- BFM slave asserts WREADY 4 cycles before AWREADY, then BVALID 2 cycles later -> WVALID drops first, AWVALID held until its handshake, exactly one RSP_VALID.
- TIMEOUT=16, slave never asserts ARREADY:
  - ARVALID is high 16 cycles then drops.
  - RSP_VALID with RSP_TIMEOUT=1, RSP_RESP=2.
  - CMD_READY=1 afterward.
  - A subsequent normal read succeeds.
- resetn low 1 cycle while in WR_RESP -> BREADY=0, no RSP_VALID, CMD_READY=1 after reset.
- CMD_VALID held continuously with alternating write/read -> one command accepted per RSP_VALID cycle, no command lost or duplicated.
